// File: rtl/rr_rsp_demux_pkg.sv
// Shared helpers for the round-robin response demultiplexer.
//   wrap_inc : pointer increment that wraps to 0 after depth-1, so that
//              ordering FIFOs of any depth, including non-power-of-2, work.
package rr_rsp_demux_pkg;

  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned depth);
    return ((ptr + 1) >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_rsp_idx_fifo.sv
// Ordering FIFO holding the granted port index of each outstanding request.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : synchronous clear; overrides push/pop in the same cycle
//   push_i/data_i : write an index (ignored while full)
//   pop_i         : retire the head entry (ignored while empty)
//   data_o        : head entry
//   full_o        : Depth entries outstanding
//   empty_o       : no entries outstanding
// When StoreData is 0 only the occupancy counter is kept and data_o is '0.
module rr_rsp_idx_fifo
  import rr_rsp_demux_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned Width     = 1,
  parameter bit          StoreData = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  ptr_t rd_ptr, wr_ptr;
  cnt_t cnt;
  logic do_push, do_pop;

  assign full_o  = (cnt == cnt_t'(Depth));
  assign empty_o = (cnt == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_t'(wrap_inc(32'(wr_ptr), Depth));
      if (do_pop)  rd_ptr <= ptr_t'(wrap_inc(32'(rd_ptr), Depth));
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + cnt_t'(1);
        2'b01:   cnt <= cnt - cnt_t'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  if (StoreData) begin : g_store
    logic [Width-1:0] mem [Depth];

    // Storage needs no reset: the head is only consumed while not empty.
    always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

    assign data_o = mem[rd_ptr];
  end else begin : g_no_store
    assign data_o = '0;
  end

endmodule

// File: rtl/rr_rsp_demux.sv
// Response return path for an N:1 round-robin request arbiter.
// Each accepted request logs its granted port index in an ordering FIFO;
// in-order responses from the shared slave are steered to the port at the
// FIFO head and the entry is retired on the response handshake.
//   clk_i, rst_ni   : clock, async active-low reset
//   flush_i         : drop all outstanding entries (sync)
//   push_valid_i    : request accepted downstream this cycle
//   push_idx_i      : arbiter index of that request
//   push_ready_o    : room for another outstanding request (gate arbiter gnt)
//   rsp_valid_i/rsp_ready_o/rsp_data_i : response from the slave
//   rsp_valid_o/rsp_ready_i/rsp_data_o : per-port responses (data broadcast)
//   rsp_idx_o       : port index at FIFO head ('0 when empty)
//   empty_o         : no outstanding transactions
module rr_rsp_demux
  import rr_rsp_demux_pkg::*;
#(
  parameter int unsigned NumOut    = 64,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter type         idx_t     = logic [IdxWidth-1:0]
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_valid_i,
  input  logic [IdxWidth-1:0] push_idx_i,
  output logic                push_ready_o,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  DataType             rsp_data_i,
  output logic [NumOut-1:0]   rsp_valid_o,
  input  logic [NumOut-1:0]   rsp_ready_i,
  output DataType             rsp_data_o,
  output logic [IdxWidth-1:0] rsp_idx_o,
  output logic                empty_o
);

  logic fifo_full, fifo_empty, pop;
  idx_t head;

  // push_ready_o reflects occupancy only; a same-cycle pop never frees a slot.
  assign push_ready_o = ~fifo_full;
  assign empty_o      = fifo_empty;
  assign pop          = rsp_valid_i & rsp_ready_o;

  rr_rsp_idx_fifo #(
    .Depth     (MaxTrans),
    .Width     (IdxWidth),
    .StoreData (NumOut > 1)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_valid_i),
    .data_i  (push_idx_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    for (int unsigned i = 0; i < NumOut; i++) begin
      if (!fifo_empty && (head == idx_t'(i))) begin
        rsp_valid_o[i] = rsp_valid_i;
        rsp_ready_o    = rsp_ready_i[i];
      end
    end
  end

  assign rsp_data_o = rsp_data_i;
  assign rsp_idx_o  = fifo_empty ? '0 : head;

  // Protocol checks
  a_rsp_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_i && !rsp_ready_o) |=> rsp_valid_i);
  a_rsp_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_i && !rsp_ready_o) |=> $stable(rsp_data_i));
  a_push_when_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_valid_i |-> push_ready_o);
  a_push_idx_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_valid_i |-> (32'(push_idx_i) < NumOut));
  a_valid_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
  a_no_rsp_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_empty |-> (rsp_valid_o == '0));

endmodule

// File: tb/tb_rr_rsp_demux.sv
module tb_rr_rsp_demux;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // DUT a: NumOut=4, MaxTrans=4
  logic        flush, pv, prdy, rv, rrdy, emp;
  logic [1:0]  pidx, ridx;
  logic [3:0]  rvo, rri;
  logic [15:0] rd, rdo;

  // DUT b: NumOut=4, MaxTrans=3
  logic        flush_b, pv_b, prdy_b, rv_b, rrdy_b, emp_b;
  logic [1:0]  pidx_b, ridx_b;
  logic [3:0]  rvo_b, rri_b;
  logic [15:0] rd_b, rdo_b;

  rr_rsp_demux #(.NumOut(4), .DataWidth(16), .MaxTrans(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
    .push_valid_i(pv), .push_idx_i(pidx), .push_ready_o(prdy),
    .rsp_valid_i(rv), .rsp_ready_o(rrdy), .rsp_data_i(rd),
    .rsp_valid_o(rvo), .rsp_ready_i(rri), .rsp_data_o(rdo),
    .rsp_idx_o(ridx), .empty_o(emp)
  );

  rr_rsp_demux #(.NumOut(4), .DataWidth(16), .MaxTrans(3)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_b),
    .push_valid_i(pv_b), .push_idx_i(pidx_b), .push_ready_o(prdy_b),
    .rsp_valid_i(rv_b), .rsp_ready_o(rrdy_b), .rsp_data_i(rd_b),
    .rsp_valid_o(rvo_b), .rsp_ready_i(rri_b), .rsp_data_o(rdo_b),
    .rsp_idx_o(ridx_b), .empty_o(emp_b)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic p_v, input logic [1:0] p_i, input logic r_v,
                       input logic [15:0] r_d, input logic [3:0] r_r);
    @(negedge clk_i);
    pv = p_v; pidx = p_i; rv = r_v; rd = r_d; rri = r_r;
    #1;
  endtask

  task automatic drive_b(input logic p_v, input logic [1:0] p_i, input logic r_v,
                         input logic [15:0] r_d);
    @(negedge clk_i);
    pv_b = p_v; pidx_b = p_i; rv_b = r_v; rd_b = r_d; rri_b = 4'b1111;
    #1;
  endtask

  logic [1:0] tbl [11] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
  int         q[$];
  logic [3:0] exp_oh;

  initial begin
    flush = 0; pv = 0; pidx = 0; rv = 0; rd = 0; rri = 0;
    flush_b = 0; pv_b = 0; pidx_b = 0; rv_b = 0; rd_b = 0; rri_b = 0;

    // Reset state, including a response offered while in reset
    #2;
    rv = 1; rri = 4'b1111;
    #1;
    check("rst_empty",     emp,  1);
    check("rst_push_rdy",  prdy, 1);
    check("rst_valid_o",   rvo,  4'b0000);
    check("rst_ready_o",   rrdy, 0);
    check("rst_idx",       ridx, 0);
    check("rst_b_empty",   emp_b, 1);
    rv = 0; rri = 0;
    @(negedge clk_i);
    rst_ni = 1;

    // Push 2,0,3; first response arrives with the first push and is served next cycle
    drive(1, 2'd2, 1, 16'hA000, 4'b1111);
    check("first_push_stall_rdy", rrdy, 0);
    check("first_push_stall_vo",  rvo,  4'b0000);
    check("first_push_empty",     emp,  1);
    drive(1, 2'd0, 1, 16'hA000, 4'b1111);
    check("rsp0_valid_o", rvo,  4'b0100);
    check("rsp0_ready_o", rrdy, 1);
    check("rsp0_data",    rdo,  16'hA000);
    check("rsp0_idx",     ridx, 2);
    drive(1, 2'd3, 1, 16'hA001, 4'b1111);
    check("rsp1_valid_o", rvo, 4'b0001);
    check("rsp1_data",    rdo, 16'hA001);
    drive(0, 2'd0, 1, 16'hA002, 4'b1111);
    check("rsp2_valid_o", rvo, 4'b1000);
    check("rsp2_data",    rdo, 16'hA002);
    drive(0, 2'd0, 0, 16'h0000, 4'b1111);
    check("drained_empty",   emp,  1);
    check("drained_valid_o", rvo,  4'b0000);

    // Fill to MaxTrans
    drive(1, 2'd1, 0, 16'h0000, 4'b1111);
    drive(1, 2'd2, 0, 16'h0000, 4'b1111);
    drive(1, 2'd3, 0, 16'h0000, 4'b1111);
    drive(1, 2'd0, 0, 16'h0000, 4'b1111);
    check("three_outstanding_rdy", prdy, 1);
    // Full with a pop this cycle: push_ready_o must stay low
    drive(0, 2'd0, 1, 16'hB000, 4'b1111);
    check("full_pop_push_rdy", prdy, 0);
    check("full_pop_valid_o",  rvo,  4'b0010);
    check("full_pop_ready_o",  rrdy, 1);
    drive(1, 2'd1, 0, 16'h0000, 4'b1111);
    check("after_pop_push_rdy", prdy, 1);
    // Entries now 2,3,0,1
    drive(0, 2'd0, 1, 16'hB001, 4'b1111);
    check("refull_push_rdy", prdy, 0);
    check("order_b1_vo",     rvo,  4'b0100);
    check("order_b1_data",   rdo,  16'hB001);
    drive(0, 2'd0, 1, 16'hB002, 4'b1111);
    check("order_b2_vo", rvo, 4'b1000);
    drive(0, 2'd0, 1, 16'hB003, 4'b1111);
    check("order_b3_vo", rvo, 4'b0001);

    // Port 1 at head, not ready for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'd0, 1, 16'hB004, 4'b1101);
      check("stall_ready_o", rrdy, 0);
      check("stall_valid_o", rvo,  4'b0010);
      check("stall_data",    rdo,  16'hB004);
      check("stall_idx",     ridx, 1);
      check("stall_not_empty", emp, 0);
    end
    drive(0, 2'd0, 1, 16'hB004, 4'b1111);
    check("unstall_ready_o", rrdy, 1);
    drive(0, 2'd0, 0, 16'h0000, 4'b1111);
    check("single_pop_empty", emp, 1);

    // Flush with 3 outstanding plus a concurrent push of idx 2
    drive(1, 2'd0, 0, 16'h0000, 4'b1111);
    drive(1, 2'd1, 0, 16'h0000, 4'b1111);
    drive(1, 2'd2, 0, 16'h0000, 4'b1111);
    drive(1, 2'd2, 1, 16'hC000, 4'b0000);
    flush = 1;
    check("preflush_valid_o", rvo,  4'b0001);
    check("preflush_ready_o", rrdy, 0);
    drive(0, 2'd0, 1, 16'hC000, 4'b0000);
    flush = 0;
    check("flush_empty",    emp,  1);
    check("flush_valid_o",  rvo,  4'b0000);
    check("flush_ready_o",  rrdy, 0);
    check("flush_push_rdy", prdy, 1);
    drive(1, 2'd3, 1, 16'hC000, 4'b0000);
    check("empty_stall_rdy", rrdy, 0);
    drive(0, 2'd0, 1, 16'hC000, 4'b1111);
    check("post_flush_vo",  rvo,  4'b1000);
    check("post_flush_idx", ridx, 3);
    check("post_flush_rdy", rrdy, 1);
    drive(0, 2'd0, 0, 16'h0000, 4'b1111);
    check("post_flush_empty", emp, 1);

    // Asynchronous reset in the middle of a response
    drive(1, 2'd1, 0, 16'h0000, 4'b1111);
    drive(1, 2'd2, 1, 16'hE000, 4'b1111);
    check("pre_reset_vo", rvo, 4'b0010);
    #2;
    rst_ni = 0;
    #1;
    check("async_rst_empty",    emp,  1);
    check("async_rst_push_rdy", prdy, 1);
    check("async_rst_valid_o",  rvo,  4'b0000);
    check("async_rst_ready_o",  rrdy, 0);
    check("async_rst_idx",      ridx, 0);
    pv = 0; rv = 0;
    @(negedge clk_i);
    rst_ni = 1;

    // MaxTrans=3: push+pop at cnt=2 across pointer wraps, against a scoreboard
    for (int k = 0; k < 2; k++) begin
      drive_b(1, tbl[k], 0, 16'h0000);
      q.push_back(int'(tbl[k]));
    end
    for (int k = 2; k < 10; k++) begin
      drive_b(1, tbl[k], 1, 16'hD000 + 16'(k));
      exp_oh = '0;
      exp_oh[q[0]] = 1'b1;
      check("sb_valid_o",  rvo_b,  exp_oh);
      check("sb_idx",      ridx_b, q[0]);
      check("sb_data",     rdo_b,  16'hD000 + 16'(k));
      check("sb_push_rdy", prdy_b, 1);
      void'(q.pop_front());
      q.push_back(int'(tbl[k]));
    end
    drive_b(1, tbl[10], 0, 16'h0000);
    q.push_back(int'(tbl[10]));
    for (int j = 0; j < 3; j++) begin
      drive_b(0, 2'd0, 1, 16'hD100 + 16'(j));
      if (j == 0) check("sb_full_push_rdy", prdy_b, 0);
      exp_oh = '0;
      exp_oh[q[0]] = 1'b1;
      check("sb_drain_valid_o", rvo_b,  exp_oh);
      check("sb_drain_ready_o", rrdy_b, 1);
      void'(q.pop_front());
    end
    drive_b(0, 2'd0, 0, 16'h0000);
    check("sb_final_empty", emp_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
